// File: rtl/span_pkg.sv
// Shared types and constants for the SPAN margin sequencer.
package span_pkg;

    localparam int DEF_DATA_W = 16;

    localparam int ENG_SCAN   = 0;
    localparam int ENG_CROSS  = 1;
    localparam int ENG_SPREAD = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        SUM,
        DONE,
        ERROR
    } seq_state_e;

endpackage

// File: rtl/span_sat_adder3.sv
// Three-input unsigned saturating adder for margin components.
// Purely combinational; no flow control.
module span_sat_adder3 #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    // Two guard bits hold the worst case of three full-scale operands.
    logic [DATA_W+1:0] wide;

    assign wide = {2'b00, a} + {2'b00, b} + {2'b00, c};
    assign ovf  = |wide[DATA_W+1:DATA_W];
    assign sum  = ovf ? {DATA_W{1'b1}} : wide[DATA_W-1:0];

endmodule

// File: rtl/span_calc_sequencer.sv
// Sequences one SPAN margin run over the scan/cross/spread engines with timeout and abort.
// Latency: go->start 2 cycles, last done->margin_valid 2 cycles; engines are not backpressured.
module span_calc_sequencer
    import span_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic              scan_done,
    input  logic              cross_done,
    input  logic              spread_done,
    input  logic [DATA_W-1:0] scan_result,
    input  logic [DATA_W-1:0] cross_result,
    input  logic [DATA_W-1:0] spread_result,
    output logic              start_scan,
    output logic              start_cross,
    output logic              start_spread,
    output logic              busy,
    output logic              margin_valid,
    output logic [DATA_W-1:0] margin,
    output logic              overflow,
    output logic              timeout_err,
    output logic [2:0]        done_mask
);

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [DATA_W-1:0] scan_cap;
    logic [DATA_W-1:0] cross_cap;
    logic [DATA_W-1:0] spread_cap;
    logic [DATA_W-1:0] sat_sum;
    logic              sat_ovf;
    logic [2:0]        done_in;
    logic [2:0]        done_all;
    logic              run_nxt;

    assign done_in[ENG_SCAN]   = scan_done;
    assign done_in[ENG_CROSS]  = cross_done;
    assign done_in[ENG_SPREAD] = spread_done;
    assign done_all            = done_mask | done_in;
    assign run_nxt             = (state_nxt == RUN) || (state_nxt == SUM);

    span_sat_adder3 #(.DATA_W(DATA_W)) u_sum (
        .a   (scan_cap),
        .b   (cross_cap),
        .c   (spread_cap),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (go && !abort) state_nxt = LAUNCH;
            LAUNCH: state_nxt = abort ? IDLE : RUN;
            RUN: begin
                // A completing done beats a same-cycle timeout.
                if (abort)                                      state_nxt = IDLE;
                else if (done_all == 3'b111)                    state_nxt = SUM;
                else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_nxt = ERROR;
            end
            SUM:    state_nxt = abort ? IDLE : DONE;
            DONE, ERROR: begin
                if (abort)   state_nxt = IDLE;
                else if (go) state_nxt = LAUNCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_scan   <= 1'b0;
            start_cross  <= 1'b0;
            start_spread <= 1'b0;
            busy         <= 1'b0;
            margin_valid <= 1'b0;
            margin       <= '0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
            done_mask    <= 3'b000;
            tmo_cnt      <= '0;
            scan_cap     <= '0;
            cross_cap    <= '0;
            spread_cap   <= '0;
        end else begin
            start_scan   <= run_nxt;
            start_cross  <= run_nxt;
            start_spread <= run_nxt;
            busy         <= (state_nxt == LAUNCH) || run_nxt;
            margin_valid <= (state_nxt == DONE);
            timeout_err  <= (state_nxt == ERROR);

            if (state_nxt == LAUNCH) begin
                done_mask  <= 3'b000;
                overflow   <= 1'b0;
                margin     <= '0;
                tmo_cnt    <= '0;
                scan_cap   <= '0;
                cross_cap  <= '0;
                spread_cap <= '0;
            end

            if (state == RUN) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (scan_done && !done_mask[ENG_SCAN]) begin
                    done_mask[ENG_SCAN] <= 1'b1;
                    scan_cap            <= scan_result;
                end
                if (cross_done && !done_mask[ENG_CROSS]) begin
                    done_mask[ENG_CROSS] <= 1'b1;
                    cross_cap            <= cross_result;
                end
                if (spread_done && !done_mask[ENG_SPREAD]) begin
                    done_mask[ENG_SPREAD] <= 1'b1;
                    spread_cap            <= spread_result;
                end
            end

            if (state == SUM && state_nxt == DONE) begin
                margin   <= sat_sum;
                overflow <= sat_ovf;
            end

            if (state_nxt == ERROR) margin <= '0;
        end
    end

endmodule

// File: tb/tb_span_calc_sequencer.sv
// Directed self-checking bench for span_calc_sequencer (TIMEOUT_CYCLES=16).
module tb_span_calc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        abort;
    logic        scan_done;
    logic        cross_done;
    logic        spread_done;
    logic [15:0] scan_result;
    logic [15:0] cross_result;
    logic [15:0] spread_result;
    logic        start_scan;
    logic        start_cross;
    logic        start_spread;
    logic        busy;
    logic        margin_valid;
    logic [15:0] margin;
    logic        overflow;
    logic        timeout_err;
    logic [2:0]  done_mask;
    logic [6:0]  st;

    int checks   = 0;
    int failures = 0;

    // Encodings: LAUNCH 0001000, RUN/SUM 1111000, DONE 0000100 (+ovf 0000110), ERROR 0000001.
    assign st = {start_scan, start_cross, start_spread, busy, margin_valid, overflow, timeout_err};

    always #5 clk = ~clk;

    span_calc_sequencer #(.DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .abort         (abort),
        .scan_done     (scan_done),
        .cross_done    (cross_done),
        .spread_done   (spread_done),
        .scan_result   (scan_result),
        .cross_result  (cross_result),
        .spread_result (spread_result),
        .start_scan    (start_scan),
        .start_cross   (start_cross),
        .start_spread  (start_spread),
        .busy          (busy),
        .margin_valid  (margin_valid),
        .margin        (margin),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .done_mask     (done_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle done pulse; results carry junk whenever their done is low.
    task automatic pulse(input logic [2:0] d, input logic [15:0] s, input logic [15:0] c,
                         input logic [15:0] p);
        scan_done     = d[0];
        cross_done    = d[1];
        spread_done   = d[2];
        scan_result   = d[0] ? s : 16'hDEAD;
        cross_result  = d[1] ? c : 16'hDEAD;
        spread_result = d[2] ? p : 16'hDEAD;
        tick();
        scan_done     = 1'b0;
        cross_done    = 1'b0;
        spread_done   = 1'b0;
        scan_result   = 16'hBEEF;
        cross_result  = 16'hBEEF;
        spread_result = 16'hBEEF;
    endtask

    task automatic launch();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        go    = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({st, done_mask, margin} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs st=%b mask=%b margin=%h expected all zero", st, done_mask, margin);
        end
        reset = 1'b1;
        go    = 1'b0;
        tick();
        checks++;
        if (st !== 7'b0000000) begin
            failures++;
            $display("FAIL reset_idle st=%b expected 0000000", st);
        end
    endtask

    task automatic test_nominal();
        launch();
        checks++;
        if (st !== 7'b0001000) begin
            failures++;
            $display("FAIL nom_launch st=%b expected 0001000", st);
        end
        tick();
        checks++;
        if (st !== 7'b1111000) begin
            failures++;
            $display("FAIL nom_run_start st=%b expected 1111000", st);
        end
        tick(); tick();
        pulse(3'b001, 16'd100, 16'd0, 16'd0);
        checks++;
        if (done_mask !== 3'b001) begin
            failures++;
            $display("FAIL nom_mask_scan mask=%b expected 001", done_mask);
        end
        tick(); tick(); tick();
        pulse(3'b010, 16'd0, 16'd20, 16'd0);
        checks++;
        if (done_mask !== 3'b011) begin
            failures++;
            $display("FAIL nom_mask_cross mask=%b expected 011", done_mask);
        end
        tick(); tick();
        pulse(3'b100, 16'd0, 16'd0, 16'd7);
        checks++;
        if (st !== 7'b1111000 || done_mask !== 3'b111) begin
            failures++;
            $display("FAIL nom_sum st=%b mask=%b expected 1111000 111", st, done_mask);
        end
        tick();
        checks++;
        if (st !== 7'b0000100 || margin !== 16'd127) begin
            failures++;
            $display("FAIL nom_done st=%b margin=%0d expected 0000100 127", st, margin);
        end
        tick();
        checks++;
        if (st !== 7'b0000100 || margin !== 16'd127) begin
            failures++;
            $display("FAIL nom_done_hold st=%b margin=%0d expected 0000100 127", st, margin);
        end
    endtask

    task automatic test_rerun_sticky();
        launch();
        checks++;
        if (st !== 7'b0001000 || margin !== 16'd0) begin
            failures++;
            $display("FAIL rerun_launch st=%b margin=%0d expected 0001000 0", st, margin);
        end
        tick();
        pulse(3'b001, 16'd50, 16'd0, 16'd0);
        pulse(3'b001, 16'd999, 16'd0, 16'd0);
        pulse(3'b010, 16'd0, 16'd60, 16'd0);
        pulse(3'b100, 16'd0, 16'd0, 16'd70);
        tick();
        checks++;
        if (st !== 7'b0000100 || margin !== 16'd180) begin
            failures++;
            $display("FAIL rerun_sticky st=%b margin=%0d expected 0000100 180", st, margin);
        end
    endtask

    task automatic test_saturate();
        launch();
        tick();
        pulse(3'b111, 16'hFFF0, 16'h0020, 16'h0001);
        checks++;
        if (st !== 7'b1111000 || done_mask !== 3'b111) begin
            failures++;
            $display("FAIL sat_sum st=%b mask=%b expected 1111000 111", st, done_mask);
        end
        tick();
        checks++;
        if (st !== 7'b0000110 || margin !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_done st=%b margin=%h expected 0000110 ffff", st, margin);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, margin_valid} !== 2'b00 || margin !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_abort_done busy/valid=%b margin=%h expected 00 ffff", {busy, margin_valid}, margin);
        end
    endtask

    task automatic test_timeout();
        launch();
        tick();
        pulse(3'b001, 16'd1, 16'd0, 16'd0);
        pulse(3'b010, 16'd0, 16'd2, 16'd0);
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (st !== 7'b1111000) begin
            failures++;
            $display("FAIL tmo_pre st=%b expected 1111000 after 15 run cycles", st);
        end
        tick();
        checks++;
        if (st !== 7'b0000001 || done_mask !== 3'b011 || margin !== 16'd0) begin
            failures++;
            $display("FAIL tmo_error st=%b mask=%b margin=%0d expected 0000001 011 0", st, done_mask, margin);
        end
        launch();
        checks++;
        if (st !== 7'b0001000 || done_mask !== 3'b000) begin
            failures++;
            $display("FAIL tmo_relaunch st=%b mask=%b expected 0001000 000", st, done_mask);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (st !== 7'b0000000) begin
            failures++;
            $display("FAIL tmo_abort_launch st=%b expected 0000000", st);
        end
    endtask

    task automatic test_abort_midrun();
        logic seen_valid;
        launch();
        tick();
        pulse(3'b001, 16'd9, 16'd0, 16'd0);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (st !== 7'b0000000 || done_mask !== 3'b001) begin
            failures++;
            $display("FAIL abort_run st=%b mask=%b expected 0000000 001", st, done_mask);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_valid = seen_valid | margin_valid;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_valid margin_valid rose=%b expected 0", seen_valid);
        end
        go    = 1'b1;
        abort = 1'b1;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        checks++;
        if (st !== 7'b0000000) begin
            failures++;
            $display("FAIL go_abort_idle st=%b expected 0000000", st);
        end
        tick();
        checks++;
        if (st !== 7'b0000000) begin
            failures++;
            $display("FAIL go_abort_idle_hold st=%b expected 0000000", st);
        end
    endtask

    task automatic test_reset_midrun();
        launch();
        tick();
        pulse(3'b001, 16'd5, 16'd0, 16'd0);
        pulse(3'b010, 16'd0, 16'd6, 16'd0);
        reset = 1'b0;
        tick();
        checks++;
        if ({st, done_mask, margin} !== 26'd0) begin
            failures++;
            $display("FAIL reset_midrun st=%b mask=%b margin=%h expected all zero", st, done_mask, margin);
        end
        reset = 1'b1;
        tick();
        launch();
        tick();
        pulse(3'b111, 16'd1, 16'd2, 16'd3);
        tick();
        checks++;
        if (st !== 7'b0000100 || margin !== 16'd6) begin
            failures++;
            $display("FAIL reset_rerun st=%b margin=%0d expected 0000100 6", st, margin);
        end
    endtask

    initial begin
        reset         = 1'b0;
        go            = 1'b0;
        abort         = 1'b0;
        scan_done     = 1'b0;
        cross_done    = 1'b0;
        spread_done   = 1'b0;
        scan_result   = 16'hBEEF;
        cross_result  = 16'hBEEF;
        spread_result = 16'hBEEF;
        test_reset();
        test_nominal();
        test_rerun_sticky();
        test_saturate();
        test_timeout();
        test_abort_midrun();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/span_calc_sequencer.md
Name: span_calc_sequencer

Overview:
- Sequences one SPAN initial-margin calculation across the three margin engines: scanning risk, cross-commodity charge and intermonth/tier spread charge.
- Sits between the host-facing register file and the engines, replacing offset-triggered starts with an explicit GO/ABORT command, per-engine done collection, timeout supervision and a saturating final sum.
- Presents a registered result and status to the host read path.

Parameters:
- DATA_W, 16, width of each engine result and of the final margin.
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before the timeout error; must be at least 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- go  in  1  single-cycle command pulse: portfolio loaded, start calculation
- abort  in  1  single-cycle command pulse: cancel the run and return to IDLE
- scan_done  in  1  scanning-risk engine done (level or pulse)
- cross_done  in  1  cross-commodity engine done (level or pulse)
- spread_done  in  1  spread-charge engine done (level or pulse)
- scan_result  in  DATA_W  scanning risk value, sampled when scan_done is seen
- cross_result  in  DATA_W  cross-commodity charge, sampled when cross_done is seen
- spread_result  in  DATA_W  tier spread charge, sampled when spread_done is seen
- start_scan  out  1  run enable for the scanning engine; low holds the engine cleared
- start_cross  out  1  run enable for the cross-commodity engine
- start_spread  out  1  run enable for the spread engine
- busy  out  1  high in LAUNCH, RUN and SUM
- margin_valid  out  1  high in DONE
- margin  out  DATA_W  final initial margin
- overflow  out  1  saturation occurred in the last SUM
- timeout_err  out  1  the run exceeded TIMEOUT_CYCLES
- done_mask  out  3  sticky per-engine done flags {spread, cross, scan}, for debug readback

Behaviour:
- Reset (reset==0 at posedge): state IDLE. All outputs 0 (margin 0, done_mask 000). Captured results cleared. Timeout counter cleared. Reset has priority over every input, including mid-run.
- States: IDLE, LAUNCH, RUN, SUM, DONE, ERROR.
- IDLE:
  - go=1 -> LAUNCH; clear done_mask, overflow, timeout_err and margin.
  - abort is ignored.
- LAUNCH (1 cycle):
  - Drives start_* low for one cycle to force the engines clear.
  - Then -> RUN.
- RUN:
  - start_scan, start_cross and start_spread are held high together.
  - The timeout counter increments each cycle.
  - Each done input sets its done_mask bit and captures its result in the same cycle. Later toggles of that done input are ignored (sticky).
  - When done_mask==111, including a same-cycle triple done -> SUM.
  - If the counter reaches TIMEOUT_CYCLES with the mask incomplete -> ERROR. If the last done arrives in the timeout cycle, done wins.
- SUM (1 cycle):
  - margin = saturate(scan+cross+spread), computed as a DATA_W+2 bit unsigned sum.
  - If sum > 2^DATA_W-1: margin = all ones and overflow = 1.
  - start_* stay high; then -> DONE.
- DONE:
  - margin_valid = 1, start_* = 0, and margin is held.
  - go -> LAUNCH (new run; margin_valid falls the next cycle).
  - abort -> IDLE; margin is retained but margin_valid = 0.
- ERROR:
  - timeout_err = 1, start_* = 0, margin = 0, busy = 0.
  - go -> LAUNCH, which clears timeout_err. abort -> IDLE, which clears timeout_err.
- abort in LAUNCH, RUN or SUM -> IDLE next cycle. start_* drop, the captured done_mask is kept for debug, and no result or error is reported.
- go while busy is ignored. If go and abort arrive in the same cycle, abort wins, then go is ignored.
- Latency: go-to-start_* high is 2 cycles. Last done-to-margin_valid is 2 cycles (RUN->SUM, SUM->DONE).
- All outputs are registered.

Decomposition:
- Package span_pkg:
  - seq_state_e enum {IDLE, LAUNCH, RUN, SUM, DONE, ERROR}
  - ENG_SCAN=0, ENG_CROSS=1, ENG_SPREAD=2 index constants
  - DATA_W default constant
- Sub-module span_sat_adder3: a combinational 3-input unsigned saturating adder, DATA_W parameter, outputs sum and ovf. It is reused wherever margin components are combined.
- The FSM, capture registers and timeout counter live in the top module.

Test Plan:
- Nominal: go; dones at cycles 5/9/12 with results 100/20/7 -> margin=127, margin_valid 2 cycles after the spread_done, overflow=0, start_* high through SUM.
- Simultaneous and saturating: all three dones in one cycle with results 0xFFF0/0x0020/0x0001 -> margin=0xFFFF, overflow=1, one SUM cycle.
- Timeout: TIMEOUT_CYCLES=16, only scan_done and cross_done asserted -> ERROR after 16 RUN cycles, timeout_err=1, done_mask=011, start_*=0, then go clears timeout_err and relaunches.
- Abort mid-run: go, scan_done, abort at RUN cycle 4 -> IDLE the next cycle, start_*=0, margin_valid never rises, done_mask=001; go+abort same cycle in IDLE -> stays IDLE.
- Reset mid-run: reset low during RUN with partial dones -> all outputs 0 and IDLE next edge; a subsequent go runs a clean calculation with correct margin.
- Re-run from DONE and sticky done: go in DONE with a new result set -> margin_valid falls, the new margin is reported; a pulsed scan_done repeated with a changed result in RUN keeps the first-captured value.
